// File: rtl/sdr_read_arbiter_if.sv
// rtl/sdr_read_arbiter_if.sv - requester and read-engine signal bundle for sdr_read_arbiter
interface sdr_read_arbiter_if #(
   parameter int NREQ    = 2,
   parameter int ADDR_W  = 32,
   parameter int NELEM_W = 30
);
   logic [NREQ-1:0]         req_valid;
   logic [NREQ*ADDR_W-1:0]  req_baseaddr;
   logic [NREQ*NELEM_W-1:0] req_nelems;
   logic [NREQ-1:0]         req_ack;
   logic [NREQ-1:0]         req_done;
   logic [NREQ-1:0]         req_err;
   logic                    sdr_readstart;
   logic [ADDR_W-1:0]       sdr_baseaddr;
   logic [NELEM_W-1:0]      sdr_nelems;
   logic                    sdr_readend;

   modport slave (
      input  req_valid, req_baseaddr, req_nelems, sdr_readend,
      output req_ack, req_done, req_err, sdr_readstart, sdr_baseaddr, sdr_nelems
   );

   modport master (
      output req_valid, req_baseaddr, req_nelems, sdr_readend,
      input  req_ack, req_done, req_err, sdr_readstart, sdr_baseaddr, sdr_nelems
   );
endinterface

// File: rtl/sdr_read_arbiter.sv
// rtl/sdr_read_arbiter.sv - round-robin arbiter sharing the avalon_sdr read engine among NREQ requesters
// Define SDR_ARB_TIMEOUT_EN to add the WAIT-state watchdog (req_err, timeout_flag).
module sdr_read_arbiter #(
   parameter int NREQ        = 2,
   parameter int ADDR_W      = 32,
   parameter int NELEM_W     = 30,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                     clkin,
   input  logic                     sdr_reset,
   sdr_read_arbiter_if.slave        bus,
   output logic                     busy,
   output logic [$clog2(NREQ)-1:0]  owner,
   output logic                     timeout_flag
);
   localparam int PW = $clog2(NREQ);

   if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
      $error("sdr_read_arbiter: unsupported NREQ or TIMEOUT_CYC");
   end

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

   state_t             state, state_nx;
   logic [PW-1:0]      ptr, owner_q, pick, cand;
   logic               found;
   logic [ADDR_W-1:0]  addr_q;
   logic [NELEM_W-1:0] nelems_q;
   logic               first_wait;
   logic               expire;
   logic [NREQ-1:0]    owner_oh;

   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = PW'((int'(ptr) + i) % NREQ);
         if (!found && bus.req_valid[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   // readend is still high from the previous transfer in the first WAIT cycle
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (found) state_nx = S_START;
         S_START: state_nx = (nelems_q != '0) ? S_WAIT : S_DONE;
         S_WAIT:  if (expire || (!first_wait && bus.sdr_readend)) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clkin or posedge sdr_reset) begin
      if (sdr_reset) begin
         state      <= S_IDLE;
         ptr        <= '0;
         owner_q    <= '0;
         addr_q     <= '0;
         nelems_q   <= '0;
         first_wait <= 1'b0;
      end else begin
         state      <= state_nx;
         first_wait <= (state == S_START);
         if (state == S_IDLE && found) begin
            owner_q  <= pick;
            addr_q   <= bus.req_baseaddr[pick*ADDR_W +: ADDR_W];
            nelems_q <= bus.req_nelems[pick*NELEM_W +: NELEM_W];
         end
         if (state == S_DONE)
            ptr <= PW'((int'(owner_q) + 1) % NREQ);
      end
   end

   assign owner_oh          = NREQ'(1) << owner_q;
   assign busy              = (state != S_IDLE);
   assign owner             = owner_q;
   assign bus.req_ack       = (state == S_START) ? owner_oh : '0;
   assign bus.req_done      = (state == S_DONE) ? owner_oh : '0;
   assign bus.sdr_readstart = (state == S_START) && (nelems_q != '0);
   assign bus.sdr_baseaddr  = addr_q;
   assign bus.sdr_nelems    = nelems_q;

`ifdef SDR_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC) + 1;

   logic [TW-1:0] wd_cnt;
   logic          err_q;
   logic          to_flag;

   assign expire = (state == S_WAIT) && (wd_cnt == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clkin or posedge sdr_reset) begin
      if (sdr_reset) begin
         wd_cnt  <= '0;
         err_q   <= 1'b0;
         to_flag <= 1'b0;
      end else begin
         if (state == S_START)
            wd_cnt <= '0;
         else if (state == S_WAIT)
            wd_cnt <= wd_cnt + 1'b1;
         err_q   <= expire;
         to_flag <= to_flag | expire;
      end
   end

   assign bus.req_err   = (state == S_DONE && err_q) ? owner_oh : '0;
   assign timeout_flag  = to_flag;
`else
   assign expire        = 1'b0;
   assign bus.req_err   = '0;
   assign timeout_flag  = 1'b0;
`endif
endmodule

// File: tb/tb_sdr_read_arbiter.sv
// tb/tb_sdr_read_arbiter.sv - directed self-checking bench for sdr_read_arbiter
module tb_sdr_read_arbiter;
   localparam int NREQ    = 2;
   localparam int ADDR_W  = 32;
   localparam int NELEM_W = 30;

   logic       clkin;
   logic       sdr_reset;
   logic       busy;
   logic [0:0] owner;
   logic       timeout_flag;
   int         n_checks;
   int         n_errors;

   sdr_read_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .NELEM_W(NELEM_W)) bus ();

   sdr_read_arbiter #(
      .NREQ(NREQ), .ADDR_W(ADDR_W), .NELEM_W(NELEM_W), .TIMEOUT_CYC(16)
   ) dut (
      .clkin(clkin),
      .sdr_reset(sdr_reset),
      .bus(bus),
      .busy(busy),
      .owner(owner),
      .timeout_flag(timeout_flag)
   );

   initial clkin = 1'b0;
   always #5 clkin = ~clkin;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clkin);
      #1;
   endtask

   task automatic wait_ack(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 8; k++) begin
         step();
         if (bus.req_ack != '0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      bit                ok;
      logic [NREQ-1:0]   exp_oh;
      logic [ADDR_W-1:0] exp_addr;
      int                exp_order [4] = '{0, 1, 0, 1};

      n_checks          = 0;
      n_errors          = 0;
      sdr_reset         = 1'b1;
      bus.req_valid     = '0;
      bus.req_baseaddr  = '0;
      bus.req_nelems    = '0;
      bus.sdr_readend   = 1'b0;
      step();
      step();
      chk("rst_busy", busy, 0);
      chk("rst_ack", bus.req_ack, 0);
      chk("rst_done", bus.req_done, 0);
      chk("rst_readstart", bus.sdr_readstart, 0);
      chk("rst_owner", owner, 0);
      chk("rst_nelems", bus.sdr_nelems, 0);
      chk("rst_tflag", timeout_flag, 0);
      sdr_reset = 1'b0;
      step();

      // single request from requester 0, readend 6 cycles after readstart
      bus.req_valid  = 2'b01;
      bus.req_baseaddr = {32'h0000_0000, 32'h0000_0000};
      bus.req_nelems   = {30'd0, 30'd2};
      step();
      chk("t2_ack", bus.req_ack, 2'b01);
      chk("t2_readstart", bus.sdr_readstart, 1);
      chk("t2_nelems", bus.sdr_nelems, 2);
      chk("t2_busy", busy, 1);
      bus.req_valid = '0;
      for (int k = 2; k <= 7; k++) begin
         step();
         chk($sformatf("t2_nodone_c%0d", k), bus.req_done, 0);
         chk($sformatf("t2_nostart_c%0d", k), bus.sdr_readstart, 0);
      end
      bus.sdr_readend = 1'b1;
      step();
      chk("t2_done", bus.req_done, 2'b01);
      chk("t2_err", bus.req_err, 0);
      bus.sdr_readend = 1'b0;
      step();
      chk("t2_idle_busy", busy, 0);
      chk("t2_idle_done", bus.req_done, 0);

      // reset while in WAIT abandons the transfer
      bus.req_valid    = 2'b01;
      bus.req_baseaddr = {32'h0000_0000, 32'h1111_2222};
      bus.req_nelems   = {30'd0, 30'd4};
      step();
      chk("t1_ack", bus.req_ack, 2'b01);
      bus.req_valid = '0;
      step();
      chk("t1_wait_busy", busy, 1);
      #2;
      sdr_reset = 1'b1;
      #1;
      chk("t1_busy", busy, 0);
      chk("t1_ack0", bus.req_ack, 0);
      chk("t1_readstart", bus.sdr_readstart, 0);
      chk("t1_done0", bus.req_done, 0);
      chk("t1_addr", bus.sdr_baseaddr, 0);
      step();
      sdr_reset       = 1'b0;
      bus.sdr_readend = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("t1_nodone%0d", k), bus.req_done, 0);
      end
      bus.sdr_readend = 1'b0;

      // round robin with both requesters held and readend stuck high
      bus.req_baseaddr = {32'hB000_0001, 32'hA000_0000};
      bus.req_nelems   = {30'd5, 30'd3};
      bus.sdr_readend  = 1'b1;
      bus.req_valid    = 2'b11;
      for (int g = 0; g < 4; g++) begin
         exp_oh   = (exp_order[g] == 0) ? 2'b01 : 2'b10;
         exp_addr = (exp_order[g] == 0) ? 32'hA000_0000 : 32'hB000_0001;
         wait_ack(ok);
         chk($sformatf("t3_ack_seen%0d", g), ok, 1);
         chk($sformatf("t3_ack%0d", g), bus.req_ack, exp_oh);
         chk($sformatf("t3_owner%0d", g), owner, exp_order[g]);
         chk($sformatf("t3_addr%0d", g), bus.sdr_baseaddr, exp_addr);
         chk($sformatf("t3_nelems%0d", g), bus.sdr_nelems, (exp_order[g] == 0) ? 3 : 5);
         step();
         chk($sformatf("t3_wait1_%0d", g), bus.req_done, 0);
         step();
         chk($sformatf("t3_wait2_%0d", g), bus.req_done, 0);
         step();
         chk($sformatf("t3_done%0d", g), bus.req_done, exp_oh);
         step();
         chk($sformatf("t3_idle%0d", g), busy, 0);
      end
      bus.req_valid   = '0;
      bus.sdr_readend = 1'b0;
      step();

      // stale readend held high when entering WAIT
      bus.req_valid    = 2'b01;
      bus.req_baseaddr = {32'hB000_0001, 32'h5555_0000};
      bus.req_nelems   = {30'd5, 30'd7};
      bus.sdr_readend  = 1'b1;
      step();
      chk("t4_ack", bus.req_ack, 2'b01);
      bus.req_valid = '0;
      step();
      chk("t4_wait1_done", bus.req_done, 0);
      chk("t4_wait1_busy", busy, 1);
      step();
      chk("t4_wait2_done", bus.req_done, 0);
      step();
      chk("t4_done", bus.req_done, 2'b01);
      bus.sdr_readend = 1'b0;
      step();
      chk("t4_idle", busy, 0);

      // zero-length request from requester 1
      bus.req_valid  = 2'b10;
      bus.req_nelems = {30'd0, 30'd7};
      step();
      chk("t5_ack", bus.req_ack, 2'b10);
      chk("t5_readstart", bus.sdr_readstart, 0);
      chk("t5_owner", owner, 1);
      bus.req_valid = '0;
      step();
      chk("t5_done", bus.req_done, 2'b10);
      chk("t5_readstart2", bus.sdr_readstart, 0);
      step();
      chk("t5_idle", busy, 0);
      chk("t5_addr_held", bus.sdr_baseaddr, 32'hB000_0001);
      chk("t5_nelems_held", bus.sdr_nelems, 0);

      // readend never rises
      bus.req_valid  = 2'b01;
      bus.req_nelems = {30'd0, 30'd1};
      step();
      chk("t6_ack", bus.req_ack, 2'b01);
      bus.req_valid = '0;
`ifdef SDR_ARB_TIMEOUT_EN
      for (int k = 2; k <= 17; k++) step();
      chk("t6_nodone_c17", bus.req_done, 0);
      chk("t6_noflag_c17", timeout_flag, 0);
      step();
      chk("t6_done", bus.req_done, 2'b01);
      chk("t6_err", bus.req_err, 2'b01);
      chk("t6_flag", timeout_flag, 1);
      step();
      chk("t6_idle", busy, 0);
      chk("t6_err_clr", bus.req_err, 0);
      chk("t6_flag_sticky", timeout_flag, 1);
      sdr_reset = 1'b1;
      step();
      chk("t6_flag_rst", timeout_flag, 0);
      sdr_reset = 1'b0;
      step();
`else
      for (int k = 2; k <= 40; k++) step();
      chk("t6_still_busy", busy, 1);
      chk("t6_nodone", bus.req_done, 0);
      chk("t6_no_err", bus.req_err, 0);
      chk("t6_no_flag", timeout_flag, 0);
      bus.sdr_readend = 1'b1;
      step();
      chk("t6_done", bus.req_done, 2'b01);
      chk("t6_err", bus.req_err, 0);
      bus.sdr_readend = 1'b0;
      step();
      chk("t6_idle", busy, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
